// File: rtl/alu_nbit_seq.sv
// Handshaked W-bit ALU with persistent C/Z/N/V flag register, carry-chained add/sub,
// logical right shift and an iterative LSB-first shift-add multiplier.
module alu_nbit_seq #(
  parameter int unsigned W = 8,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   opcode_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] result_o,
  output logic         c_flag_o,
  output logic         z_flag_o,
  output logic         n_flag_o,
  output logic         v_flag_o,
  output logic         busy_o
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    result_q, result_d;
  logic            c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic [W-1:0]    bx;
  logic            cin;
  logic [W:0]      sum;
  logic [W:0]      shr_ext;
  logic [W-1:0]    alu_res;
  logic            alu_c, alu_v;
  logic [2*W-1:0]  acc_nxt;

  assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StMul);
  assign result_o    = result_q;
  assign c_flag_o    = c_q;
  assign z_flag_o    = z_q;
  assign n_flag_o    = n_q;
  assign v_flag_o    = v_q;

  // Shared adder: SUB/SBB invert B; ADC/SBB chain the stored carry.
  always_comb begin
    bx      = ((opcode_i == 4'd1) || (opcode_i == 4'd9)) ? ~b_i : b_i;
    cin     = (opcode_i == 4'd1) ? 1'b1 :
              ((opcode_i == 4'd8) || (opcode_i == 4'd9)) ? c_q : 1'b0;
    sum     = {1'b0, a_i} + {1'b0, bx} + {{W{1'b0}}, cin};
    // Extra LSB catches the last bit shifted out; zero when the amount is zero.
    shr_ext = {a_i, 1'b0} >> b_i[SW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode_i)
      4'd0, 4'd1, 4'd8, 4'd9: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = (a_i[W-1] == bx[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      4'd2: alu_res = a_i & b_i;
      4'd3: alu_res = a_i | b_i;
      4'd4: alu_res = a_i ^ b_i;
      4'd5: alu_res = (a_i > b_i) ? {{(W-1){1'b0}}, 1'b1} : '0;
      4'd6: begin
        alu_res = {a_i[W-2:0], 1'b0};
        alu_c   = a_i[W-1];
      end
      4'd7: begin
        alu_res = {b_i[W-2:0], 1'b0};
        alu_c   = b_i[W-1];
      end
      4'd10: begin
        alu_res = shr_ext[W:1];
        alu_c   = shr_ext[0];
      end
      default: ;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (opcode_i == 4'd11) begin
            state_d  = StMul;
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            c_d      = alu_c;
            z_d      = (alu_res == '0);
            n_d      = alu_res[W-1];
            v_d      = alu_v;
          end
        end else if ((state_q == StDone) && out_ready_i) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d  = StDone;
          result_d = acc_nxt[W-1:0];
          c_d      = |acc_nxt[2*W-1:W];
          z_d      = (acc_nxt[W-1:0] == '0);
          n_d      = acc_nxt[W-1];
          v_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed bench for alu_nbit_seq at W=8; flags compared as {C,Z,N,V}.
module tb_alu_nbit_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_flag, z_flag, n_flag, v_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_nbit_seq #(.W(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .opcode_i    (opcode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .c_flag_o    (c_flag),
    .z_flag_o    (z_flag),
    .n_flag_o    (n_flag),
    .v_flag_o    (v_flag),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, c_flag, z_flag, n_flag, v_flag};
  endfunction

  // Drive at a negedge, accept on the next posedge, return at the following negedge.
  task automatic issue(input logic [3:0] op_in, input logic [7:0] a_in, input logic [7:0] b_in);
    in_valid = 1'b1;
    opcode   = op_in;
    a        = a_in;
    b        = b_in;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opcode    = 4'd0;
    a         = '0;
    b         = '0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", result, 32'h00);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", out_valid, 0);

    // ADD then ADC back-to-back.
    issue(4'd0, 8'hFF, 8'h01);
    chk("add_valid", out_valid, 1);
    chk("add_result", result, 32'h00);
    chk("add_flags", flags(), 32'b1100);
    issue(4'd8, 8'h00, 8'h00);
    chk("adc_valid", out_valid, 1);
    chk("adc_result", result, 32'h01);
    chk("adc_flags", flags(), 32'b0000);
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    chk("hold_result", result, 32'h01);

    // SUB overflow, then clear C, then SBB with C=0.
    issue(4'd1, 8'h80, 8'h01);
    chk("sub_result", result, 32'h7F);
    chk("sub_flags", flags(), 32'b1001);
    issue(4'd2, 8'hFF, 8'h0F);
    chk("and_result", result, 32'h0F);
    chk("and_flags", flags(), 32'b0000);
    issue(4'd9, 8'h00, 8'h00);
    chk("sbb_result", result, 32'hFF);
    chk("sbb_flags", flags(), 32'b0010);

    // MUL 0x10*0x11: busy for W cycles; requests during MUL are ignored.
    issue(4'd11, 8'h10, 8'h11);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_out_valid", out_valid, 0);
      if (i == 0) begin
        in_valid = 1'b1;
        opcode   = 4'd0;
        a        = 8'hAA;
        b        = 8'h55;
      end
      if (i == 7) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("mul1_valid", out_valid, 1);
    chk("mul1_busy", busy, 0);
    chk("mul1_result", result, 32'h10);
    chk("mul1_flags", flags(), 32'b1000);

    issue(4'd11, 8'h0F, 8'h03);
    repeat (7) @(negedge clk);
    chk("mul2_early", out_valid, 0);
    @(negedge clk);
    chk("mul2_valid", out_valid, 1);
    chk("mul2_result", result, 32'h2D);
    chk("mul2_flags", flags(), 32'b0000);

    // Reset during the 4th MUL cycle discards the operation.
    issue(4'd11, 8'h10, 8'h11);
    repeat (3) @(negedge clk);
    chk("mulrst_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mulrst_busy", busy, 0);
    chk("mulrst_out_valid", out_valid, 0);
    chk("mulrst_in_ready", in_ready, 1);
    chk("mulrst_result", result, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("mulrst_no_output", out_valid, 0);
    end

    // Backpressure: result held for 5 cycles, then consumed.
    out_ready = 1'b0;
    issue(4'd4, 8'hF0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 32'hCC);
      chk("bp_flags", flags(), 32'b0010);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_consumed", out_valid, 0);
    chk("bp_hold_result", result, 32'hCC);

    // Shifts, compare and reserved opcode.
    issue(4'd10, 8'hB5, 8'h03);
    chk("shr3_result", result, 32'h16);
    chk("shr3_flags", flags(), 32'b1000);
    issue(4'd10, 8'hB5, 8'h00);
    chk("shr0_result", result, 32'hB5);
    chk("shr0_flags", flags(), 32'b0010);
    issue(4'd5, 8'h05, 8'h03);
    chk("gt_result", result, 32'h01);
    chk("gt_flags", flags(), 32'b0000);
    issue(4'd6, 8'h81, 8'h00);
    chk("shla_result", result, 32'h02);
    chk("shla_flags", flags(), 32'b1000);
    issue(4'd10, 8'hB5, 8'h00);
    issue(4'd13, 8'hFF, 8'hFF);
    chk("rsvd_result", result, 32'h00);
    chk("rsvd_flags", flags(), 32'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
